ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Inhibits the bus, issues request-to-send, shifts data/parity/stop on device clock edges, checks device ACK.
//  Sits beside the keyboard receiver; top level builds the open-drain pads as (oe ? 1'b0 : 1'bz).
//  oBusy lets the receiver path discard line activity during a host frame.
// PARAMETERS
//  INHIBIT_CYCLES        5000     clock-low hold before request (100 us @ 50 MHz)
//  START_TIMEOUT_CYCLES  750000   max wait for first device falling edge after clock release (15 ms)
//  PACKET_TIMEOUT_CYCLES 100000   max time from first device edge to ACK (2 ms)
//  FILTER_CYCLES         8        consecutive equal samples needed to accept a PS2 clock level change
// PORTS
//  iCLK_50      in   1  system clock, 50 MHz
//  Reset        in   1  asynchronous, active-high reset
//  iPS2_CLK     in   1  PS/2 clock pad level (asynchronous)
//  iPS2_DAT     in   1  PS/2 data pad level (asynchronous)
//  oPS2_CLK_OE  out  1  1 = pull PS/2 clock low
//  oPS2_DAT_OE  out  1  1 = pull PS/2 data low
//  iTxData      in   8  byte to send, sampled with iTxStart
//  iTxStart     in   1  1-cycle request; accepted only when oBusy=0
//  oBusy        out  1  high from accept edge until oDone
//  oDone        out  1  1-cycle pulse at end of transaction (success or error)
//  oError       out  1  1-cycle pulse coincident with oDone on failure
//  oErrCode     out  2  0 ok, 1 no ACK, 2 start timeout, 3 packet timeout; held until next accept
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE, counters 0; both OE drop immediately, also mid-frame.
//  Inputs: 2-flop synchroniser each; clock then glitch-filtered by FILTER_CYCLES; fall = filtered 1->0.
//  IDLE: iTxStart=1 -> latch iTxData, compute odd parity (~^data), oBusy=1, oErrCode=0, -> INHIBIT.
//  INHIBIT: CLK_OE=1 for INHIBIT_CYCLES; at terminal count DAT_OE=1 (start bit) -> REQ.
//  REQ: one cycle, both OE=1; then CLK_OE=0 -> WAIT_DEV, START counter cleared.
//  WAIT_DEV: first fall -> drive D0 (DAT_OE=~D0), bitcnt=1 -> XFER; START_TIMEOUT expiry -> ERR(2).
//  XFER: each fall advances bitcnt: 2..8 drive D1..D7, 9 parity, 10 stop (DAT_OE=0 released).
//   Fall 11: sample synced data: 0 -> WAIT_IDLE; 1 -> ERR(1). PACKET counter runs from first fall.
//  WAIT_IDLE: wait filtered clk=1 and data=1, then oDone=1, oBusy=0 -> IDLE.
//  PACKET_TIMEOUT expiry in XFER or WAIT_IDLE -> ERR(3).
//  ERR: both OE=0, oErrCode latched, oDone=oError=1 for one cycle, oBusy=0 -> IDLE.
//  Data changes only after fall (device samples on rise); DAT_OE never changes while filtered clk high.
//  iTxStart while oBusy=1: ignored, no queueing, latched byte unchanged.
//  iTxStart in the oDone cycle: ignored; accepted from the following cycle.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on error code 1 or 3, restart from INHIBIT with the same byte, up to 2 retries;
//   oBusy stays high, oDone/oError only after final attempt; code 2 never retried.
//  Not defined: single attempt, every error reported immediately.
// TESTING
//  Send 0xED, device model ACKs -> line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; oDone, oErrCode=0.
//  Send 0x00, model leaves data high on fall 11 -> parity bit 1; oError+oDone, oErrCode=1.
//  No device clock -> CLK_OE high exactly 5001 cycles; after START_TIMEOUT oErrCode=2, OEs=0.
//  Model stops after 5 falls -> after PACKET_TIMEOUT oErrCode=3; with RETRY_EN: 3 INHIBIT phases seen.
//  iTxStart 0x55 then 0xAA while busy -> only 0x55 on wire, single oDone.
//  Reset at fall 6 -> both OEs 0 and oBusy 0 before the next clock edge; next 0xF4 sends normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift frame on device clock falls, check ACK.
// Optional PS2_TX_RETRY_EN: no-ACK and packet-timeout failures are retried up to twice with the same byte.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES        = 5000,
  parameter int START_TIMEOUT_CYCLES  = 750000,
  parameter int PACKET_TIMEOUT_CYCLES = 100000,
  parameter int FILTER_CYCLES         = 8
) (
  input  logic       iCLK_50,
  input  logic       Reset,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic       oPS2_CLK_OE,
  output logic       oPS2_DAT_OE,
  input  logic [7:0] iTxData,
  input  logic       iTxStart,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [1:0] oErrCode
);

  // state     | meaning
  // IDLE      | waiting for iTxStart
  // INHIBIT   | clock held low for INHIBIT_CYCLES
  // REQ       | clock and data both low (request-to-send)
  // WAIT_DEV  | clock released, waiting for first device fall
  // XFER      | D0..D7, parity, stop on falls 1..10; ACK sampled on fall 11
  // WAIT_IDLE | waiting for clock and data both high
  // ERR       | release bus, then retry or report
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, WAIT_DEV, XFER, WAIT_IDLE, ERR} state_t;

  localparam int T1   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int TMAX = (T1 > PACKET_TIMEOUT_CYCLES) ? T1 : PACKET_TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int FW   = $clog2(FILTER_CYCLES + 1);

  state_t          state;
  logic [TW-1:0]   tmr;
  logic [3:0]      bitcnt;
  logic [8:0]      frame;
  logic [1:0]      err_code;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            clk_filt, clk_fall;
  logic [FW-1:0]   filt_cnt;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]      retry_cnt;
`endif

  always_ff @(posedge iCLK_50 or posedge Reset) begin
    if (Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_s1   <= iPS2_CLK;
      clk_s2   <= clk_s1;
      dat_s1   <= iPS2_DAT;
      dat_s2   <= dat_s1;
      clk_fall <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        clk_fall <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK_50 or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      tmr         <= '0;
      bitcnt      <= '0;
      frame       <= '0;
      err_code    <= '0;
      oPS2_CLK_OE <= 1'b0;
      oPS2_DAT_OE <= 1'b0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oError      <= 1'b0;
      oErrCode    <= '0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= '0;
`endif
    end else begin
      oDone  <= 1'b0;
      oError <= 1'b0;
      case (state)
        IDLE: begin
          if (iTxStart && !oDone) begin
            frame       <= {~^iTxData, iTxData};
            oBusy       <= 1'b1;
            oErrCode    <= '0;
            oPS2_CLK_OE <= 1'b1;
            tmr         <= TW'(INHIBIT_CYCLES - 1);
            state       <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            retry_cnt   <= '0;
`endif
          end
        end
        INHIBIT: begin
          if (tmr == '0) begin
            oPS2_DAT_OE <= 1'b1;
            state       <= REQ;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        REQ: begin
          oPS2_CLK_OE <= 1'b0;
          tmr         <= TW'(START_TIMEOUT_CYCLES - 1);
          state       <= WAIT_DEV;
        end
        WAIT_DEV: begin
          if (clk_fall) begin
            oPS2_DAT_OE <= ~frame[0];
            bitcnt      <= 4'd1;
            tmr         <= TW'(PACKET_TIMEOUT_CYCLES - 1);
            state       <= XFER;
          end else if (tmr == '0) begin
            err_code <= 2'd2;
            state    <= ERR;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        XFER: begin
          if (tmr == '0) begin
            err_code <= 2'd3;
            state    <= ERR;
          end else begin
            tmr <= tmr - 1'b1;
            // bitcnt holds the number of falls seen so far
            if (clk_fall) begin
              bitcnt <= bitcnt + 1'b1;
              if (bitcnt <= 4'd8) begin
                oPS2_DAT_OE <= ~frame[bitcnt];
              end else if (bitcnt == 4'd9) begin
                oPS2_DAT_OE <= 1'b0;
              end else if (dat_s2) begin
                err_code <= 2'd1;
                state    <= ERR;
              end else begin
                state <= WAIT_IDLE;
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (tmr == '0) begin
            err_code <= 2'd3;
            state    <= ERR;
          end else begin
            tmr <= tmr - 1'b1;
            if (clk_filt && dat_s2) begin
              oDone <= 1'b1;
              oBusy <= 1'b0;
              state <= IDLE;
            end
          end
        end
        ERR: begin
`ifdef PS2_TX_RETRY_EN
          if (err_code != 2'd2 && retry_cnt != 2'd2) begin
            retry_cnt   <= retry_cnt + 1'b1;
            oPS2_CLK_OE <= 1'b1;
            oPS2_DAT_OE <= 1'b0;
            tmr         <= TW'(INHIBIT_CYCLES - 1);
            state       <= INHIBIT;
          end else
`endif
          begin
            oPS2_CLK_OE <= 1'b0;
            oPS2_DAT_OE <= 1'b0;
            oErrCode    <= err_code;
            oDone       <= 1'b1;
            oError      <= 1'b1;
            oBusy       <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on a wired-AND bus plus a per-cycle transaction-level checker.
// Follows PS2_TX_RETRY_EN when defined, expecting three attempts for retryable failures.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int STO  = 400;
  localparam int PTO  = 700;
  localparam int FILT = 8;
  localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int ATT = 3;
`else
  localparam int ATT = 1;
`endif

  logic       iCLK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       iTxStart = 1'b0;
  logic [7:0] iTxData = 8'h00;
  logic       oPS2_CLK_OE, oPS2_DAT_OE, oBusy, oDone, oError;
  logic [1:0] oErrCode;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_pad, dat_pad;

  assign clk_pad = dev_clk & ~oPS2_CLK_OE;
  assign dat_pad = dev_dat & ~oPS2_DAT_OE;

  always #5 iCLK_50 = ~iCLK_50;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT_CYCLES(STO),
    .PACKET_TIMEOUT_CYCLES(PTO), .FILTER_CYCLES(FILT)
  ) dut (
    .iCLK_50(iCLK_50), .Reset(Reset), .iPS2_CLK(clk_pad), .iPS2_DAT(dat_pad),
    .oPS2_CLK_OE(oPS2_CLK_OE), .oPS2_DAT_OE(oPS2_DAT_OE), .iTxData(iTxData),
    .iTxStart(iTxStart), .oBusy(oBusy), .oDone(oDone), .oError(oError), .oErrCode(oErrCode)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  bit         model_busy = 0;
  bit         was_busy;
  logic [7:0] acc_byte = 8'h00;
  logic [1:0] exp_code = 2'd0;
  logic [1:0] last_code = 2'd0;
  logic [1:0] exp_ec;
  logic       exp_busy;
  int         done_count = 0;
  int         inh_count = 0;
  int         cur_run = 0;
  int         last_run = 0;
  logic       prev_clk_oe = 1'b0;
  logic       prev_dat_oe = 1'b0;
  bit         dat_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as seen on the wire: {stop, odd parity, data}
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int   ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    p = ((ones % 2) == 0);
    return {1'b1, p, b};
  endfunction

  always @(negedge iCLK_50) begin
    if (Reset) begin
      model_busy = 0;
      last_code  = 2'd0;
    end
    was_busy = model_busy;
    exp_busy = (model_busy && !oDone);
    chk("busy", oBusy, exp_busy);
    if (!model_busy) begin
      chk("idle_quiet", {oDone, oError, oPS2_CLK_OE, oPS2_DAT_OE}, 4'b0000);
      exp_ec = last_code;
    end else if (oDone) begin
      exp_ec = exp_code;
      chk("done_error", oError, (exp_code != 2'd0));
      chk("done_bus_released", {oPS2_CLK_OE, oPS2_DAT_OE}, 2'b00);
      done_count++;
      last_code  = exp_code;
      model_busy = 0;
    end else begin
      exp_ec = 2'd0;
      chk("no_error_midframe", oError, 1'b0);
    end
    chk("errcode", oErrCode, exp_ec);
    if (dat_chk && (oPS2_DAT_OE !== prev_dat_oe)) chk("dat_change_clk_low", clk_pad, 1'b0);
    if (oPS2_CLK_OE) begin
      if (!prev_clk_oe) inh_count++;
      cur_run++;
    end else if (prev_clk_oe) begin
      last_run = cur_run;
      cur_run  = 0;
    end
    prev_clk_oe = oPS2_CLK_OE;
    prev_dat_oe = oPS2_DAT_OE;
    if (!Reset && iTxStart && !was_busy && !oDone) begin
      model_busy = 1;
      acc_byte   = iTxData;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK_50);
    #1;
  endtask

  task automatic start_pulse(input logic [7:0] b);
    iTxData  = b;
    iTxStart = 1'b1;
    tick(1);
    iTxStart = 1'b0;
  endtask

  // Device: wait for request-to-send, clock out n_falls periods, sample data on each rise.
  task automatic dev_frame(input int n_falls, input bit ack, input bit stop_low,
                           output logic [9:0] bits, output bit ok);
    bit seen;
    seen = 0;
    ok   = 0;
    bits = '0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      tick(1);
      if (dat_pad == 1'b0 && clk_pad == 1'b1) seen = 1;
    end
    if (!seen) return;
    tick(30);
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11 && ack) begin
        dev_dat = 1'b0;
        tick(5);
      end
      dev_clk = 1'b0;
      if (stop_low && i == n_falls) begin
        ok = 1;
        return;
      end
      tick(HALF);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = dat_pad;
      tick(HALF);
    end
    dev_dat = 1'b1;
    ok = 1;
  endtask

  task automatic run_txn(input logic [7:0] b, input int n_falls, input bit ack, input int attempts,
                         input logic [1:0] code, input bit dchk, input logic [9:0] lit, input bit use_lit,
                         input bit extra, input logic [7:0] xb);
    int d0;
    d0       = done_count;
    exp_code = code;
    dat_chk  = dchk;
    start_pulse(b);
    fork
      begin
        for (int a = 0; a < attempts; a++) begin
          logic [9:0] bits;
          bit         ok;
          dev_frame(n_falls, ack, 1'b0, bits, ok);
          chk("dev_saw_request", ok, 1'b1);
          if (ok && n_falls >= 11) begin
            chk("frame_vs_model", bits, frame_of(acc_byte));
            if (use_lit) chk("frame_literal", bits, lit);
          end
        end
      end
      begin
        int t;
        t = 0;
        while (done_count == d0 && t < 10000) begin
          tick(1);
          t++;
        end
        chk("done_within_bound", (done_count != d0), 1'b1);
      end
      begin
        if (extra) begin
          tick(10);
          start_pulse(xb);
        end
      end
    join
    tick(20);
    chk("single_done", done_count - d0, 1);
    dat_chk = 0;
  endtask

  initial begin
    int         i0;
    logic [9:0] bits;
    bit         ok;
    tick(5);
    chk("rst_oe", {oPS2_CLK_OE, oPS2_DAT_OE}, 2'b00);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done_err", {oDone, oError}, 2'b00);
    chk("rst_code", oErrCode, 2'd0);
    Reset = 1'b0;
    tick(5);

    // 0xED with ACK: wire bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    run_txn(8'hED, 11, 1'b1, 1, 2'd0, 1'b1, 10'h3ED, 1'b1, 1'b0, 8'h00);
    tick(5);

    // 0x00, device never ACKs: parity 1
    run_txn(8'h00, 11, 1'b0, ATT, 2'd1, 1'b0, 10'h300, 1'b1, 1'b0, 8'h00);
    tick(5);

    // No device: clock held low for inhibit plus request cycle, then start timeout
    i0 = inh_count;
    run_txn(8'hA5, 0, 1'b0, 0, 2'd2, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
    chk("inhibit_length", last_run, INH + 1);
    chk("start_to_phases", inh_count - i0, 1);
    tick(5);

    // Device stops after 5 falls: packet timeout
    i0 = inh_count;
    run_txn(8'hFF, 5, 1'b0, ATT, 2'd3, 1'b0, 10'h000, 1'b0, 1'b0, 8'h00);
    chk("packet_to_phases", inh_count - i0, ATT);
    tick(5);

    // Second start while busy is ignored
    run_txn(8'h55, 11, 1'b1, 1, 2'd0, 1'b1, 10'h355, 1'b1, 1'b1, 8'hAA);
    tick(5);

    // Reset at fall 6 drops the bus before the next clock edge
    exp_code = 2'd0;
    start_pulse(8'hED);
    dev_frame(6, 1'b0, 1'b1, bits, ok);
    chk("reset_test_reached_fall6", ok, 1'b1);
    chk("busy_before_reset", oBusy, 1'b1);
    #1 Reset = 1'b1;
    #1;
    chk("async_rst_clk_oe", oPS2_CLK_OE, 1'b0);
    chk("async_rst_dat_oe", oPS2_DAT_OE, 1'b0);
    chk("async_rst_busy", oBusy, 1'b0);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(20);

    // Normal send after reset: 0xF4, parity 0
    run_txn(8'hF4, 11, 1'b1, 1, 2'd0, 1'b1, 10'h2F4, 1'b1, 1'b0, 8'h00);
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
